inst_dispatch: RTL and testbench
================================

# inst_dispatch

Instruction fetch/dispatch stage directly downstream of the Frodo top-level sequencer. The sequencer pulses `inst_valid` with a `pc`. This block:
- fetches the 16-bit instruction at `{mode, pc}` from a synchronous program ROM;
- decodes it and issues a one-hot start pulse to the selected functional unit (SHAKE, sampler, matrix-mul, pack);
- waits for that unit's done;
- returns a one-cycle `inst_done` pulse to the sequencer.

## Interface
Parameters:
- `NUM_UNITS`, 4, number of functional units (1..7); unit IDs 0..NUM_UNITS-1.
- `TIMEOUT`, 4096, maximum cycles in WAIT before abort (only with `DISPATCH_TIMEOUT_EN`).

Ports:
- `clk` in 1: the single clock; all logic is on the rising edge.
- `rst` in 1: reset is synchronous and active-high.
- `inst_valid` in 1: one-cycle request pulse from the sequencer.
- `pc` in 8: instruction index, sampled with `inst_valid`.
- `mode` in 2: 0 = keygen, 1 = encap, 2 = decap; sampled with `inst_valid`.
- `level` in 2: security level, sampled with `inst_valid`.
- `rom_en` out 1: ROM read enable.
- `rom_addr` out 10: ROM address, equal to `{mode, pc}`.
- `rom_rdata` in 16: ROM data, valid on the cycle after `rom_en`.
- `unit_start` out NUM_UNITS: one-hot start pulse.
- `unit_done` in NUM_UNITS: per-unit completion pulses.
- `op_code` out 4: decoded opcode for the active unit.
- `op_arg` out 9: decoded argument.
- `level_o` out 2: latched level for the active unit.
- `busy` out 1: high in every state except IDLE.
- `inst_done` out 1: one-cycle completion pulse to the sequencer.
- `err` out 1: sticky error flag; cleared only by `rst`.

## Operation
- Instruction word fields:
  - [15:13] unit ID; value 7 = NOP.
  - [12:9] opcode.
  - [8:0] argument.
- States and transitions:
  - IDLE: on `inst_valid`, register `rom_addr <= {mode, pc}` and `level_o <= level`; go to FETCH.
  - FETCH: `rom_en = 1`; go to DECODE.
  - DECODE: latch `rom_rdata` fields into `op_code`/`op_arg` and an internal unit register.
    - Unit 7 → DONE.
    - Unit ≥ NUM_UNITS and ≠ 7 → set `err`, go to DONE (the sequencer never hangs).
    - Otherwise → ISSUE.
  - ISSUE: `unit_start[unit] = 1` for exactly this cycle; go to WAIT.
  - WAIT: sample `unit_done[unit]`; when it is high, go to DONE. `unit_done` bits of other units are ignored.
  - DONE: `inst_done = 1`; go to IDLE.
- `op_code`, `op_arg` and `level_o` hold from DECODE+1 until the next accepted `inst_valid`.
- `inst_valid` seen while `busy` is ignored, sets `err`, and does not disturb the current instruction.
- `unit_done` is sampled only in WAIT. A unit may assert done as early as the first WAIT cycle (the cycle after start). Any done asserted earlier is lost.
- `rst` mid-operation: state returns to IDLE on the next edge. No `inst_done` is issued for the aborted instruction.
- Reset values: all outputs 0, including `rom_addr`, `op_code`, `op_arg`, `level_o`, `busy` and `err`.

## Timing
- Let `inst_valid` be sampled at edge T.
- `rom_en` is high in cycle T+1.
- ROM data is captured at T+2.
- `unit_start` is high in cycle T+3.
- If `unit_done` is seen at WAIT cycle W, `inst_done` is high in cycle W+1. Minimum total latency is T+5.
- NOP or illegal unit: `inst_done` is high in cycle T+3.
- `inst_done` is never high in two consecutive cycles.

## Configuration
- `DISPATCH_TIMEOUT_EN` defined:
  - A counter of width clog2(TIMEOUT+1) clears on entry to WAIT and increments each WAIT cycle.
  - When it reaches TIMEOUT without the selected `unit_done`, set `err` and go to DONE.
- Not defined: no counter; WAIT persists indefinitely until the selected `unit_done`.

## Test plan
- mode=1, pc=5, rom[0x105]=0x26A5 (unit 1, op 3, arg 0x0A5), `unit_done[1]` 10 cycles after start → `rom_addr`=0x105, `unit_start`=4'b0010 at T+3, `op_code`=3, `op_arg`=0x0A5, `inst_done` one cycle after done, `err`=0.
- rom word 0xE000 (NOP) → `inst_done` at T+3, `unit_start` never asserted.
- rom word 0xA000 (unit 5) with NUM_UNITS=4 → `err`=1 at T+3 and stays high, `inst_done` at T+3, no start pulse.
- Unit 0 issued, `unit_done`=4'b0100 pulsed, then `unit_done`=4'b0001 five cycles later → `inst_done` only after the bit-0 pulse.
- TIMEOUT=16 with the macro defined, no done → `err`=1 and `inst_done` at the cycle after the 16th WAIT cycle. Without the macro → `busy` stays 1 for 100+ cycles.
- `rst` high for one cycle during WAIT → all outputs 0 next edge; a subsequent `inst_valid` completes normally with `err`=0.

Source files
------------

// File: rtl/inst_dispatch.sv
// inst_dispatch: instruction fetch/dispatch stage below the Frodo sequencer.
// Fetches a 16-bit word from the program ROM at {mode, pc} and decodes it.
// It then pulses the start of the selected functional unit, waits for that
// unit's done, and returns a one-cycle inst_done pulse.
// Optional feature macro: DISPATCH_TIMEOUT_EN (abort WAIT after TIMEOUT cycles).
module inst_dispatch #(
   parameter int NUM_UNITS = 4,
   parameter int TIMEOUT   = 4096
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 inst_valid,
   input  logic [7:0]           pc,
   input  logic [1:0]           mode,
   input  logic [1:0]           level,
   output logic                 rom_en,
   output logic [9:0]           rom_addr,
   input  logic [15:0]          rom_rdata,
   output logic [NUM_UNITS-1:0] unit_start,
   input  logic [NUM_UNITS-1:0] unit_done,
   output logic [3:0]           op_code,
   output logic [8:0]           op_arg,
   output logic [1:0]           level_o,
   output logic                 busy,
   output logic                 inst_done,
   output logic                 err
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_FETCH  = 3'd1,
      S_DECODE = 3'd2,
      S_ISSUE  = 3'd3,
      S_WAIT   = 3'd4,
      S_DONE   = 3'd5
   } state_t;

   localparam logic [3:0] NUM_U4 = 4'(NUM_UNITS);

   state_t                state_r;
   state_t                state_nxt_s;
   logic [2:0]            unit_r;
   logic [2:0]            rd_unit_s;
   logic [NUM_UNITS-1:0]  rd_onehot_s;
   logic [NUM_UNITS-1:0]  act_onehot_s;
   logic                  done_sel_s;
   logic                  err_set_s;
   logic                  timeout_hit_s;

   assign rd_unit_s    = rom_rdata[15:13];
   assign rd_onehot_s  = NUM_UNITS'(1) << rd_unit_s;
   assign act_onehot_s = NUM_UNITS'(1) << unit_r;
   // Only the done bit of the unit that was actually started counts.
   assign done_sel_s   = |(unit_done & act_onehot_s);

`ifdef DISPATCH_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT + 1);
   logic [CW-1:0] wait_cnt_r;

   // WAIT-cycle counter: cleared while entering WAIT, counts every WAIT cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         wait_cnt_r <= {CW{1'b0}};
      end else if (state_r == S_ISSUE) begin
         wait_cnt_r <= {CW{1'b0}};
      end else if (state_r == S_WAIT) begin
         wait_cnt_r <= wait_cnt_r + CW'(1);
      end else begin
         wait_cnt_r <= wait_cnt_r;
      end
   end

   // The counter is zero in the first WAIT cycle, so TIMEOUT-1 marks the last one.
   assign timeout_hit_s = (wait_cnt_r == CW'(TIMEOUT - 1));
`else
   assign timeout_hit_s = 1'b0;
`endif

   // Next-state decode plus error detection for illegal units, timeouts and overlapping requests.
   always_comb begin
      state_nxt_s = state_r;
      err_set_s   = 1'b0;
      case (state_r)
         S_IDLE: begin
            if (inst_valid) begin
               state_nxt_s = S_FETCH;
            end else begin
               state_nxt_s = S_IDLE;
            end
         end
         S_FETCH: state_nxt_s = S_DECODE;
         S_DECODE: begin
            if (rd_unit_s == 3'd7) begin
               state_nxt_s = S_DONE;
            end else if ({1'b0, rd_unit_s} >= NUM_U4) begin
               err_set_s   = 1'b1;
               state_nxt_s = S_DONE;
            end else begin
               state_nxt_s = S_ISSUE;
            end
         end
         S_ISSUE: state_nxt_s = S_WAIT;
         S_WAIT: begin
            if (done_sel_s) begin
               state_nxt_s = S_DONE;
            end else if (timeout_hit_s) begin
               err_set_s   = 1'b1;
               state_nxt_s = S_DONE;
            end else begin
               state_nxt_s = S_WAIT;
            end
         end
         S_DONE:  state_nxt_s = S_IDLE;
         default: state_nxt_s = S_IDLE;
      endcase
      // A new request while an instruction is in flight is dropped and flagged.
      if (inst_valid && (state_r != S_IDLE)) begin
         err_set_s = 1'b1;
      end else begin
         err_set_s = err_set_s;
      end
   end

   // State register and registered outputs derived from the upcoming state.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r    <= S_IDLE;
         unit_r     <= 3'd0;
         rom_en     <= 1'b0;
         rom_addr   <= 10'd0;
         unit_start <= {NUM_UNITS{1'b0}};
         op_code    <= 4'd0;
         op_arg     <= 9'd0;
         level_o    <= 2'd0;
         busy       <= 1'b0;
         inst_done  <= 1'b0;
         err        <= 1'b0;
      end else begin
         state_r    <= state_nxt_s;
         rom_en     <= (state_nxt_s == S_FETCH);
         busy       <= (state_nxt_s != S_IDLE);
         inst_done  <= (state_nxt_s == S_DONE);
         err        <= err | err_set_s;
         if (state_nxt_s == S_ISSUE) begin
            unit_start <= rd_onehot_s;
         end else begin
            unit_start <= {NUM_UNITS{1'b0}};
         end
         if ((state_r == S_IDLE) && inst_valid) begin
            rom_addr <= {mode, pc};
            level_o  <= level;
         end else begin
            rom_addr <= rom_addr;
            level_o  <= level_o;
         end
         if (state_r == S_DECODE) begin
            unit_r  <= rd_unit_s;
            op_code <= rom_rdata[12:9];
            op_arg  <= rom_rdata[8:0];
         end else begin
            unit_r  <= unit_r;
            op_code <= op_code;
            op_arg  <= op_arg;
         end
      end
   end

endmodule

// File: tb/tb_inst_dispatch.sv
// Self-checking bench for inst_dispatch: table of instruction vectors plus
// hand-written sequences (wrong-unit done, overlapping request, timeout/hang, reset).
module tb_inst_dispatch;

   logic        clk = 1'b0;
   logic        rst;
   logic        inst_valid;
   logic [7:0]  pc;
   logic [1:0]  mode;
   logic [1:0]  level;
   logic        rom_en;
   logic [9:0]  rom_addr;
   logic [15:0] rom_rdata;
   logic [3:0]  unit_start;
   logic [3:0]  unit_done;
   logic [3:0]  op_code;
   logic [8:0]  op_arg;
   logic [1:0]  level_o;
   logic        busy;
   logic        inst_done;
   logic        err;

   int checks   = 0;
   int failures = 0;

   inst_dispatch #(.NUM_UNITS(4), .TIMEOUT(16)) dut (
      .clk(clk), .rst(rst), .inst_valid(inst_valid), .pc(pc), .mode(mode),
      .level(level), .rom_en(rom_en), .rom_addr(rom_addr), .rom_rdata(rom_rdata),
      .unit_start(unit_start), .unit_done(unit_done), .op_code(op_code),
      .op_arg(op_arg), .level_o(level_o), .busy(busy), .inst_done(inst_done),
      .err(err)
   );

   always #5 clk = ~clk;

   // Synchronous program ROM model
   logic [15:0] rom [0:1023];
   always @(posedge clk) begin
      if (rom_en) rom_rdata <= rom[rom_addr];
   end

   typedef struct packed {
      logic [3:0] op;
      logic [8:0] arg;
      logic [1:0] lvl;
      logic       err;
   } sb_t;
   sb_t sb_q[$];
   logic exp_err;
   logic prev_done = 1'b0;

   typedef struct {
      logic [1:0]  mode;
      logic [7:0]  pc;
      logic [1:0]  level;
      logic [15:0] word;
      int          delay;
      logic [3:0]  exp_start;
      logic [3:0]  exp_op;
      logic [8:0]  exp_arg;
      logic        has_unit;
      logic        legal;
   } vec_t;
   vec_t vecs[8];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   // Scoreboard: compare decoded fields and err whenever inst_done fires
   always @(negedge clk) begin
      if (inst_done) begin
         check("inst_done_back_to_back", {31'd0, prev_done}, 32'd0);
         if (sb_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL sb_unexpected_done actual=1 expected=0");
         end else begin
            sb_t e;
            e = sb_q.pop_front();
            check("sb_op_code", {28'd0, op_code}, {28'd0, e.op});
            check("sb_op_arg", {23'd0, op_arg}, {23'd0, e.arg});
            check("sb_level_o", {30'd0, level_o}, {30'd0, e.lvl});
            check("sb_err", {31'd0, err}, {31'd0, e.err});
         end
      end
      prev_done <= inst_done;
   end

   task automatic check_reset_outputs(input string name);
      check(name, {rom_en, rom_addr, unit_start, op_code, op_arg, level_o, busy, inst_done, err},
            32'd0);
   endtask

   // Drive a one-cycle request; returns at the negedge inside cycle T+1
   task automatic start_inst(input logic [1:0] m, input logic [7:0] p, input logic [1:0] l);
      @(negedge clk);
      mode = m; pc = p; level = l; inst_valid = 1'b1;
      @(negedge clk);
      inst_valid = 1'b0;
   endtask

   task automatic run_vec(input vec_t v);
      rom[{v.mode, v.pc}] = v.word;
      if (!v.legal) exp_err = 1'b1;
      sb_q.push_back({v.exp_op, v.exp_arg, v.level, exp_err});
      start_inst(v.mode, v.pc, v.level);
      check("rom_en_t1", {31'd0, rom_en}, 32'd1);
      check("rom_addr_t1", {22'd0, rom_addr}, {22'd0, v.mode, v.pc});
      check("busy_t1", {31'd0, busy}, 32'd1);
      @(negedge clk);
      check("rom_en_t2", {31'd0, rom_en}, 32'd0);
      @(negedge clk);
      check("unit_start_t3", {28'd0, unit_start}, {28'd0, v.exp_start});
      check("err_t3", {31'd0, err}, {31'd0, exp_err});
      if (v.has_unit) begin
         check("inst_done_t3", {31'd0, inst_done}, 32'd0);
         for (int i = 0; i < v.delay; i++) @(negedge clk);
         check("inst_done_before_unit_done", {31'd0, inst_done}, 32'd0);
         unit_done = v.exp_start;
         @(negedge clk);
         unit_done = 4'd0;
         check("inst_done_after_unit_done", {31'd0, inst_done}, 32'd1);
      end else begin
         check("inst_done_t3_nop", {31'd0, inst_done}, 32'd1);
      end
      @(negedge clk);
      check("inst_done_cleared", {31'd0, inst_done}, 32'd0);
      check("busy_idle", {31'd0, busy}, 32'd0);
   endtask

   task automatic pulse_reset();
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      sb_q.delete();
      exp_err = 1'b0;
   endtask

   initial begin
      logic seen_done;
      logic busy_held;
      for (int i = 0; i < 1024; i++) rom[i] = 16'h0000;
      rst = 1'b1; inst_valid = 1'b0; pc = 8'd0; mode = 2'd0; level = 2'd0;
      unit_done = 4'd0; exp_err = 1'b0;
      vecs[0] = '{2'd1, 8'h05, 2'd2, 16'h26A5, 10, 4'b0010, 4'd3,  9'h0A5, 1'b1, 1'b1};
      vecs[1] = '{2'd0, 8'h00, 2'd1, 16'h1234, 1,  4'b0001, 4'd9,  9'h034, 1'b1, 1'b1};
      vecs[2] = '{2'd2, 8'hFF, 2'd3, 16'h7FFF, 3,  4'b1000, 4'd15, 9'h1FF, 1'b1, 1'b1};
      vecs[3] = '{2'd0, 8'h03, 2'd0, 16'h4C01, 2,  4'b0100, 4'd6,  9'h001, 1'b1, 1'b1};
      vecs[4] = '{2'd1, 8'h07, 2'd1, 16'hE000, 0,  4'b0000, 4'd0,  9'h000, 1'b0, 1'b1};
      vecs[5] = '{2'd2, 8'h40, 2'd2, 16'hFFFF, 0,  4'b0000, 4'd15, 9'h1FF, 1'b0, 1'b1};
      vecs[6] = '{2'd2, 8'h09, 2'd3, 16'hA000, 0,  4'b0000, 4'd0,  9'h000, 1'b0, 1'b0};
      vecs[7] = '{2'd0, 8'h80, 2'd1, 16'hC123, 0,  4'b0000, 4'd0,  9'h123, 1'b0, 1'b0};
      repeat (2) @(negedge clk);
      check_reset_outputs("reset_outputs");
      rst = 1'b0;

      for (int k = 0; k < 8; k++) run_vec(vecs[k]);
      check("err_sticky", {31'd0, err}, 32'd1);
      pulse_reset();
      check_reset_outputs("soft_clear_outputs");

      // Early done (during ISSUE) and another unit's done are both ignored
      rom[{2'd0, 8'h10}] = 16'h0000;
      sb_q.push_back({4'd0, 9'd0, 2'd1, 1'b0});
      start_inst(2'd0, 8'h10, 2'd1);
      @(negedge clk);
      @(negedge clk);
      check("wrong_unit_start", {28'd0, unit_start}, 32'd1);
      unit_done = 4'b0001;
      @(negedge clk);
      unit_done = 4'b0100;
      @(negedge clk);
      unit_done = 4'b0000;
      for (int i = 0; i < 5; i++) begin
         check("wrong_unit_no_done", {31'd0, inst_done}, 32'd0);
         @(negedge clk);
      end
      unit_done = 4'b0001;
      @(negedge clk);
      unit_done = 4'b0000;
      check("wrong_unit_done_after_bit0", {31'd0, inst_done}, 32'd1);
      @(negedge clk);

      // inst_valid while busy: ignored, err set, current instruction intact
      sb_q.push_back({4'd6, 9'h001, 2'd2, 1'b1});
      start_inst(2'd0, 8'h03, 2'd2);
      repeat (3) @(negedge clk);
      mode = 2'd3; pc = 8'hAA; level = 2'd0; inst_valid = 1'b1;
      @(negedge clk);
      inst_valid = 1'b0;
      check("overlap_err", {31'd0, err}, 32'd1);
      check("overlap_rom_addr", {22'd0, rom_addr}, 32'h003);
      check("overlap_level", {30'd0, level_o}, 32'd2);
      unit_done = 4'b0100;
      @(negedge clk);
      unit_done = 4'b0000;
      check("overlap_done", {31'd0, inst_done}, 32'd1);
      @(negedge clk);
      check("overlap_busy_clear", {31'd0, busy}, 32'd0);
      pulse_reset();

      // No done: timeout abort when enabled, otherwise a hang that reset clears
`ifdef DISPATCH_TIMEOUT_EN
      sb_q.push_back({4'd3, 9'h0A5, 2'd1, 1'b1});
      start_inst(2'd1, 8'h05, 2'd1);
      @(negedge clk);
      @(negedge clk);
      for (int i = 1; i <= 16; i++) @(negedge clk);
      check("timeout_not_early", {31'd0, inst_done}, 32'd0);
      @(negedge clk);
      check("timeout_done", {31'd0, inst_done}, 32'd1);
      check("timeout_err", {31'd0, err}, 32'd1);
      @(negedge clk);
`else
      start_inst(2'd1, 8'h05, 2'd1);
      seen_done = 1'b0;
      busy_held = 1'b1;
      for (int i = 0; i < 120; i++) begin
         @(negedge clk);
         if (!busy) busy_held = 1'b0;
         if (inst_done) seen_done = 1'b1;
      end
      check("hang_busy_held", {31'd0, busy_held}, 32'd1);
      check("hang_no_done", {31'd0, seen_done}, 32'd0);
`endif

      // Reset during WAIT aborts silently; a new instruction then completes cleanly
      sb_q.push_back({4'd3, 9'h0A5, 2'd1, 1'b0});
      start_inst(2'd1, 8'h05, 2'd1);
      repeat (4) @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      sb_q.delete();
      exp_err = 1'b0;
      check_reset_outputs("reset_in_wait");
      @(negedge clk);
      check("reset_in_wait_no_done", {31'd0, inst_done}, 32'd0);
      run_vec(vecs[0]);
      check("post_reset_err", {31'd0, err}, 32'd0);

      check("sb_empty", sb_q.size(), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
